mac_pe: RTL and testbench

Parametrised, fully synchronous multiply-accumulate processing element for the systolic MAC array. Each valid beat computes a LANES-wide dot product of streamed activations against locally stored (weight-stationary) weights, then adds either the upstream partial sum (chain mode) or a local accumulator (accumulate mode). Activations are forwarded one cycle later to the neighbouring PE. Adds signed/unsigned arithmetic, optional saturation, a sticky overflow flag and valid qualification.

---
 rtl/mac_pkg.sv | 54 +++++
 rtl/mac_pe_if.sv | 34 +++
 rtl/mac_lane.sv | 41 ++++
 rtl/mac_pe.sv | 122 ++++++++++++
 tb/tb_mac_pe.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary MAC processing element.
package mac_pkg;

  typedef enum logic {
    ACC_CHAIN = 1'b0,
    ACC_LOCAL = 1'b1
  } acc_mode_e;

  // Widest accumulator sat_add can handle. Two headroom bits are kept above ACC_W.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic             ovf;
  } sat_res_t;

  function automatic int sum_width(input int a_w, input int w_w, input int lanes);
    return a_w + w_w + $clog2(lanes);
  endfunction

  // Operands arrive already sign- or zero-extended to MAX_W. The result is
  // confined to w bits, and is either clamped or wrapped.
  function automatic sat_res_t sat_add(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int               w,
                                       input logic             is_signed,
                                       input logic             sat);
    sat_res_t         r;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] smax;
    logic [MAX_W-1:0] smin;
    sum     = a + b;
    mask    = (MAX_W'(1) << w) - MAX_W'(1);
    smax    = mask >> 1;
    smin    = ~smax;
    r.value = sum & mask;
    r.ovf   = 1'b0;
    if (is_signed) begin
      if ($signed(sum) > $signed(smax)) begin
        r.ovf = 1'b1;
        if (sat) r.value = smax;
      end else if ($signed(sum) < $signed(smin)) begin
        r.ovf = 1'b1;
        if (sat) r.value = smin & mask;
      end
    end else if ((sum & ~mask) != '0) begin
      r.ovf = 1'b1;
      if (sat) r.value = mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_pe_if.sv
// Activation/weight/partial-sum bundle between a MAC PE and its neighbours or driver.
interface mac_pe_if #(
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24,
  parameter int LANES = 4
) ();
  // a_valid marks one beat per cycle. There is no ready: the PE accepts every
  // beat. psum_valid and a_out_valid are single-cycle strobes with no stall.
  logic                   w_load;
  logic [LANES*W_W-1:0]   w_in;
  logic                   a_valid;
  logic [LANES*A_W-1:0]   a_in;
  logic [ACC_W-1:0]       psum_in;
  logic                   signed_mode;
  logic                   sat_en;
  logic                   acc_mode;
  logic                   acc_clear;
  logic [LANES*A_W-1:0]   a_out;
  logic                   a_out_valid;
  logic [ACC_W-1:0]       psum_out;
  logic                   psum_valid;
  logic                   overflow;

  modport slave (
    input  w_load, w_in, a_valid, a_in, psum_in, signed_mode, sat_en, acc_mode, acc_clear,
    output a_out, a_out_valid, psum_out, psum_valid, overflow
  );

  modport master (
    output w_load, w_in, a_valid, a_in, psum_in, signed_mode, sat_en, acc_mode, acc_clear,
    input  a_out, a_out_valid, psum_out, psum_valid, overflow
  );
endinterface

// File: rtl/mac_lane.sv
// One multiply lane: a weight register slice plus the registered product (stage E1).
module mac_lane #(
  parameter int A_W = 8,
  parameter int W_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               w_load,
  input  logic [W_W-1:0]     w_in,
  input  logic               a_valid,
  input  logic [A_W-1:0]     a_in,
  input  logic               signed_mode,
  output logic [A_W+W_W-1:0] prod
);
  localparam int P_W = A_W + W_W;

  logic [W_W-1:0] w_q;
  logic [P_W-1:0] a_x;
  logic [P_W-1:0] w_x;
  logic [P_W-1:0] prod_next;

  // The low P_W bits of the product are correct for both signednesses once
  // each operand has been extended to P_W bits.
  always_comb begin
    a_x       = signed_mode ? P_W'($signed(a_in)) : P_W'(a_in);
    w_x       = signed_mode ? P_W'($signed(w_q))  : P_W'(w_q);
    prod_next = a_x * w_x;
  end

  // The product samples w_q before any same-cycle load lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_q  <= '0;
      prod <= '0;
    end else begin
      if (w_load)  w_q  <= w_in;
      if (a_valid) prod <= prod_next;
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Weight-stationary MAC PE: LANES-wide dot product plus a chained or locally accumulated addend.
module mac_pe
  import mac_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24,
  parameter int LANES = 4
) (
  input  logic     clock,
  input  logic     reset,
  mac_pe_if.slave  bus
);
  localparam int P_W   = A_W + W_W;
  localparam int SUM_W = sum_width(A_W, W_W, LANES);

  logic [P_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.A_W(A_W), .W_W(W_W)) u_lane (
      .clock       (clock),
      .reset       (reset),
      .w_load      (bus.w_load),
      .w_in        (bus.w_in[i*W_W +: W_W]),
      .a_valid     (bus.a_valid),
      .a_in        (bus.a_in[i*A_W +: A_W]),
      .signed_mode (bus.signed_mode),
      .prod        (prod[i])
    );
  end

  // Beat side-band carried alongside the lane products through E1.
  logic             e1_valid;
  logic [ACC_W-1:0] e1_psum;
  logic             e1_signed;
  logic             e1_sat;
  acc_mode_e        e1_mode;

  logic [SUM_W-1:0] dot;
  logic [ACC_W-1:0] addend;
  logic [MAX_W-1:0] dot_x;
  logic [MAX_W-1:0] addend_x;
  sat_res_t         res;
  logic [ACC_W-1:0] psum_next;
  logic             ovf_hit;
  logic             unused_hi;

  logic [ACC_W-1:0]       psum_q;
  logic                   psum_valid_q;
  logic [ACC_W-1:0]       acc_q;
  logic                   ovf_q;
  logic [LANES*A_W-1:0]   a_fwd_q;
  logic                   a_fwd_valid_q;

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + (e1_signed ? SUM_W'($signed(prod[i])) : SUM_W'(prod[i]));
    end
    // A clear arriving alongside an accumulate beat restarts from this beat alone.
    if (e1_mode == ACC_LOCAL) addend = bus.acc_clear ? '0 : acc_q;
    else                      addend = e1_psum;
    dot_x     = e1_signed ? MAX_W'($signed(dot))    : MAX_W'(dot);
    addend_x  = e1_signed ? MAX_W'($signed(addend)) : MAX_W'(addend);
    res       = sat_add(dot_x, addend_x, ACC_W, e1_signed, e1_sat);
    psum_next = res.value[ACC_W-1:0];
    ovf_hit   = e1_valid & res.ovf;
  end

  assign unused_hi = ^res.value[MAX_W-1:ACC_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e1_valid  <= 1'b0;
      e1_psum   <= '0;
      e1_signed <= 1'b0;
      e1_sat    <= 1'b0;
      e1_mode   <= ACC_CHAIN;
    end else begin
      e1_valid <= bus.a_valid;
      if (bus.a_valid) begin
        e1_psum   <= bus.psum_in;
        e1_signed <= bus.signed_mode;
        e1_sat    <= bus.sat_en;
        e1_mode   <= acc_mode_e'(bus.acc_mode);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      psum_valid_q <= e1_valid;
      if (e1_valid) psum_q <= psum_next;
      if (e1_valid && e1_mode == ACC_LOCAL) acc_q <= psum_next;
      else if (bus.acc_clear)               acc_q <= '0;
      if (bus.acc_clear) ovf_q <= ovf_hit;
      else if (ovf_hit)  ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_fwd_q       <= '0;
      a_fwd_valid_q <= 1'b0;
    end else begin
      a_fwd_q       <= bus.a_in;
      a_fwd_valid_q <= bus.a_valid;
    end
  end

  assign bus.psum_out    = psum_q;
  assign bus.psum_valid  = psum_valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.a_out       = a_fwd_q;
  assign bus.a_out_valid = a_fwd_valid_q;

endmodule

// File: tb/tb_mac_pe.sv
// Directed-vector bench for mac_pe: chain, signed, saturation, accumulate, reload and reset cases.
module tb_mac_pe;
  localparam int A_W = 8, W_W = 8, ACC_W = 24, LANES = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mac_pe_if #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .LANES(LANES)) bus ();

  mac_pe #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .LANES(LANES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                     input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [23:0] p,
                      input logic sgn, input logic sat, input logic mode);
    bus.a_valid     = 1'b1;
    bus.a_in        = a;
    bus.psum_in     = p;
    bus.signed_mode = sgn;
    bus.sat_en      = sat;
    bus.acc_mode    = mode;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    bus.a_in    = '0;
  endtask

  task automatic load_w(input logic [31:0] w);
    bus.w_load = 1'b1;
    bus.w_in   = w;
    tick();
    bus.w_load = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.acc_clear = 1'b1;
    tick();
    bus.acc_clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.psum_out !== 24'd0) begin errors++; $display("FAIL reset_psum: got %0h want 0", bus.psum_out); end
    checks++; if (bus.psum_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.psum_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    checks++; if (bus.a_out !== 32'd0 || bus.a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %0h/%b want 0/0", bus.a_out, bus.a_out_valid); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_chain();
    load_w(pk(8'd1, 8'd2, 8'd3, 8'd4));
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 24'd5, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++; if (bus.a_out !== pk(8'd10, 8'd20, 8'd30, 8'd40)) begin errors++; $display("FAIL chain_a_out: got %0h want 281e140a", bus.a_out); end
    checks++; if (bus.a_out_valid !== 1'b1) begin errors++; $display("FAIL chain_a_out_valid: got %b want 1", bus.a_out_valid); end
    checks++; if (bus.psum_valid !== 1'b0) begin errors++; $display("FAIL chain_early_valid: got %b want 0", bus.psum_valid); end
    tick();
    checks++; if (bus.psum_valid !== 1'b1 || bus.psum_out !== 24'd305) begin errors++; $display("FAIL chain_psum: got %0d/%b want 305/1", bus.psum_out, bus.psum_valid); end
    checks++; if (bus.a_out_valid !== 1'b0) begin errors++; $display("FAIL chain_fwd_drop: got %b want 0", bus.a_out_valid); end
    tick();
    checks++; if (bus.psum_valid !== 1'b0 || bus.psum_out !== 24'd305) begin errors++; $display("FAIL chain_bubble_hold: got %0d/%b want 305/0", bus.psum_out, bus.psum_valid); end
  endtask

  task automatic test_signed();
    load_w(pk(8'h80, 8'h80, 8'h80, 8'h80));
    beat(pk(8'h80, 8'h80, 8'h80, 8'h80), 24'hFF0000, 1'b1, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'd0 || bus.psum_valid !== 1'b1) begin errors++; $display("FAIL signed_min_psum: got %0h/%b want 0/1", bus.psum_out, bus.psum_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL signed_min_ovf: got %b want 0", bus.overflow); end
    load_w(pk(8'h7F, 8'h7F, 8'h7F, 8'h7F));
    beat(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 24'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'hFFFE04) begin errors++; $display("FAIL signed_neg_psum: got %0h want fffe04", bus.psum_out); end
  endtask

  task automatic test_saturation();
    load_w(pk(8'd1, 8'd0, 8'd0, 8'd0));
    beat(pk(8'd1, 8'd0, 8'd0, 8'd0), 24'h7FFFFF, 1'b1, 1'b1, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'h7FFFFF || bus.overflow !== 1'b1) begin errors++; $display("FAIL sat_signed: got %0h/%b want 7fffff/1", bus.psum_out, bus.overflow); end
    beat(pk(8'd1, 8'd0, 8'd0, 8'd0), 24'h7FFFFF, 1'b1, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'h800000 || bus.overflow !== 1'b1) begin errors++; $display("FAIL wrap_signed: got %0h/%b want 800000/1", bus.psum_out, bus.overflow); end
    repeat (3) tick();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    pulse_clear();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    beat(pk(8'd1, 8'd0, 8'd0, 8'd0), 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'h000000 || bus.overflow !== 1'b1) begin errors++; $display("FAIL wrap_unsigned: got %0h/%b want 0/1", bus.psum_out, bus.overflow); end
    pulse_clear();
    beat(pk(8'd1, 8'd0, 8'd0, 8'd0), 24'hFFFFFE, 1'b0, 1'b1, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'hFFFFFF || bus.overflow !== 1'b0) begin errors++; $display("FAIL unsigned_top_edge: got %0h/%b want ffffff/0", bus.psum_out, bus.overflow); end
    beat(pk(8'd1, 8'd0, 8'd0, 8'd0), 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'hFFFFFF || bus.overflow !== 1'b1) begin errors++; $display("FAIL sat_unsigned: got %0h/%b want ffffff/1", bus.psum_out, bus.overflow); end
    pulse_clear();
  endtask

  task automatic test_accumulate();
    load_w(pk(8'd1, 8'd2, 8'd3, 8'd4));
    pulse_clear();
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 24'd99, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checks++; if (bus.psum_out !== 24'd300 || bus.psum_valid !== 1'b1) begin errors++; $display("FAIL acc_beat1: got %0d/%b want 300/1", bus.psum_out, bus.psum_valid); end
    tick();
    idle();
    checks++; if (bus.psum_out !== 24'd600) begin errors++; $display("FAIL acc_beat2: got %0d want 600", bus.psum_out); end
    tick();
    checks++; if (bus.psum_out !== 24'd900) begin errors++; $display("FAIL acc_beat3: got %0d want 900", bus.psum_out); end
    tick(); tick();
    checks++; if (bus.psum_valid !== 1'b0 || bus.psum_out !== 24'd900) begin errors++; $display("FAIL acc_idle: got %0d/%b want 900/0", bus.psum_out, bus.psum_valid); end
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 24'd99, 1'b0, 1'b0, 1'b1);
    bus.acc_clear = 1'b1;
    tick(); idle(); tick();
    bus.acc_clear = 1'b0;
    checks++; if (bus.psum_out !== 24'd300 || bus.psum_valid !== 1'b1) begin errors++; $display("FAIL acc_clear_beat: got %0d/%b want 300/1", bus.psum_out, bus.psum_valid); end
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 24'd99, 1'b0, 1'b0, 1'b1);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'd600) begin errors++; $display("FAIL acc_after_clear: got %0d want 600", bus.psum_out); end
  endtask

  task automatic test_weight_reload();
    load_w(pk(8'd1, 8'd2, 8'd3, 8'd4));
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 24'd0, 1'b0, 1'b0, 1'b0);
    bus.w_load = 1'b1;
    bus.w_in   = pk(8'd2, 8'd2, 8'd2, 8'd2);
    tick();
    bus.w_load = 1'b0;
    tick();
    idle();
    checks++; if (bus.psum_out !== 24'd300) begin errors++; $display("FAIL reload_old_w: got %0d want 300", bus.psum_out); end
    tick();
    checks++; if (bus.psum_out !== 24'd200 || bus.psum_valid !== 1'b1) begin errors++; $display("FAIL reload_new_w: got %0d/%b want 200/1", bus.psum_out, bus.psum_valid); end
  endtask

  task automatic test_reset_inflight();
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 24'd0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    idle();
    reset = 1'b0;
    #1;
    checks++; if (bus.psum_valid !== 1'b0 || bus.psum_out !== 24'd0) begin errors++; $display("FAIL rst_async_psum: got %0d/%b want 0/0", bus.psum_out, bus.psum_valid); end
    checks++; if (bus.a_out !== 32'd0 || bus.a_out_valid !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_async_other: got %0h/%b/%b want 0/0/0", bus.a_out, bus.a_out_valid, bus.overflow); end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.psum_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid_%0d: got %b want 0", i, bus.psum_valid); end
    end
    beat(pk(8'd1, 8'd1, 8'd1, 8'd1), 24'd7, 1'b0, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (bus.psum_out !== 24'd7 || bus.psum_valid !== 1'b1) begin errors++; $display("FAIL rst_weights_zero: got %0d/%b want 7/1", bus.psum_out, bus.psum_valid); end
  endtask

  initial begin
    bus.w_load      = 1'b0;
    bus.w_in        = '0;
    bus.a_valid     = 1'b0;
    bus.a_in        = '0;
    bus.psum_in     = '0;
    bus.signed_mode = 1'b0;
    bus.sat_en      = 1'b0;
    bus.acc_mode    = 1'b0;
    bus.acc_clear   = 1'b0;
    test_reset();
    test_unsigned_chain();
    test_signed();
    test_saturation();
    test_accumulate();
    test_weight_reload();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
